// File: rtl/rob_id_alloc_if.sv
// rob_id_alloc_if: allocator request/response bundle between rename/dispatch and the ROB id allocator.
interface rob_id_alloc_if #(
   parameter int CONFIG_P_ISSUE_WIDTH  = 0,
   parameter int CONFIG_P_COMMIT_WIDTH = 0,
   parameter int CONFIG_P_ROB_DEPTH    = 0
);
   localparam int IW   = 1 << CONFIG_P_ISSUE_WIDTH;
   localparam int DW   = CONFIG_P_ROB_DEPTH > 0 ? CONFIG_P_ROB_DEPTH : 1;
   localparam int BW   = CONFIG_P_COMMIT_WIDTH > 0 ? CONFIG_P_COMMIT_WIDTH : 1;
   localparam int CNTW = CONFIG_P_ROB_DEPTH + CONFIG_P_COMMIT_WIDTH + 1;
   logic                         flush;
   logic [CONFIG_P_COMMIT_WIDTH:0] rob_push_size;
   logic [CONFIG_P_COMMIT_WIDTH:0] rob_commit_size;
   logic                         rob_ready;
   logic [IW*DW-1:0]             rob_free_id;
   logic [IW*BW-1:0]             rob_free_bank;
   logic [DW-1:0]                rob_head_id;
   logic [BW-1:0]                rob_head_bank;
   logic [CNTW-1:0]              rob_count;
   logic                         rob_empty;
   logic                         rob_err;
   modport master (
      output flush, rob_push_size, rob_commit_size,
      input  rob_ready, rob_free_id, rob_free_bank, rob_head_id, rob_head_bank, rob_count, rob_empty, rob_err
   );
   modport slave (
      input  flush, rob_push_size, rob_commit_size,
      output rob_ready, rob_free_id, rob_free_bank, rob_head_id, rob_head_bank, rob_count, rob_empty, rob_err
   );
endinterface

// File: rtl/rob_id_alloc.sv
// rob_id_alloc: circular ROB slot allocator with banked id mapping, flush recovery and sticky misuse flag.
module rob_id_alloc #(
   parameter int CONFIG_P_ISSUE_WIDTH  = 0,
   parameter int CONFIG_P_COMMIT_WIDTH = 0,
   parameter int CONFIG_P_ROB_DEPTH    = 0
) (
   input logic          clk,
   input logic          rst,
   rob_id_alloc_if.slave bus
);
   localparam int IW   = 1 << CONFIG_P_ISSUE_WIDTH;
   localparam int NB   = 1 << CONFIG_P_COMMIT_WIDTH;
   localparam int N    = NB << CONFIG_P_ROB_DEPTH;
   localparam int DW   = CONFIG_P_ROB_DEPTH > 0 ? CONFIG_P_ROB_DEPTH : 1;
   localparam int BW   = CONFIG_P_COMMIT_WIDTH > 0 ? CONFIG_P_COMMIT_WIDTH : 1;
   localparam int PW   = CONFIG_P_ROB_DEPTH + CONFIG_P_COMMIT_WIDTH;
   localparam int PWW  = PW > 0 ? PW : 1;
   localparam int CNTW = PW + 1;
   localparam logic [CNTW-1:0] MASK = CNTW'(N - 1);
   typedef enum logic {RUN, RECOVER} state_t;
   state_t            state_q, state_d;
   logic [PWW-1:0]    tail_q, tail_d, head_q, head_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic              err_q, err_d;
   logic [CNTW-1:0]   p, c, pe, ce, slot, head_slot;
   logic              run, push_ok, commit_ok;
   always_comb begin
      state_d   = bus.flush ? RECOVER : RUN;
      p         = CNTW'(bus.rob_push_size);
      c         = CNTW'(bus.rob_commit_size);
      run       = (state_q == RUN) && !bus.flush;
      // legality is judged against the registered count only; same-cycle traffic is not credited
      push_ok   = (p <= CNTW'(IW)) && (p <= CNTW'(N) - count_q);
      commit_ok = c <= count_q;
      pe        = (run && push_ok) ? p : '0;
      ce        = (run && commit_ok) ? c : '0;
      tail_d    = bus.flush ? '0 : PWW'((CNTW'(tail_q) + pe) & MASK);
      head_d    = bus.flush ? '0 : PWW'((CNTW'(head_q) + ce) & MASK);
      count_d   = bus.flush ? '0 : count_q + pe - ce;
      err_d     = err_q | (run & (!push_ok | !commit_ok));
   end
   always_comb begin
      slot              = '0;
      bus.rob_free_id   = '0;
      bus.rob_free_bank = '0;
      for (int i = 0; i < IW; i++) begin
         slot = (CNTW'(tail_q) + CNTW'(i)) & MASK;
         bus.rob_free_id[i*DW +: DW]   = DW'(slot >> CONFIG_P_COMMIT_WIDTH);
         bus.rob_free_bank[i*BW +: BW] = BW'(slot & CNTW'(NB - 1));
      end
   end
   assign head_slot         = CNTW'(head_q);
   assign bus.rob_head_id   = DW'(head_slot >> CONFIG_P_COMMIT_WIDTH);
   assign bus.rob_head_bank = BW'(head_slot & CNTW'(NB - 1));
   assign bus.rob_ready     = (state_q == RUN) && (count_q <= CNTW'(N - IW));
   assign bus.rob_count     = count_q;
   assign bus.rob_empty     = count_q == '0;
   assign bus.rob_err       = err_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         tail_q  <= '0;
         head_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tail_q  <= tail_d;
         head_q  <= head_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_rob_id_alloc.sv
// tb_rob_id_alloc: directed vector table plus flush-hold sequence for IW=2, NB=2, 4 entries/bank (N=8).
module tb_rob_id_alloc;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   rob_id_alloc_if #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_ROB_DEPTH(2)) bus ();
   rob_id_alloc #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_ROB_DEPTH(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   typedef struct {
      logic       r, f;
      logic [1:0] p, c;
      int         cnt;
      logic       rdy, err, emp;
      int         head, tail;
   } vec_t;
   vec_t vq[$];
   task automatic add(input logic r, f, input int p, c, cnt, input logic rdy, err, emp, input int head, tail);
      vec_t v;
      v.r = r; v.f = f; v.p = 2'(p); v.c = 2'(c); v.cnt = cnt;
      v.rdy = rdy; v.err = err; v.emp = emp; v.head = head; v.tail = tail;
      vq.push_back(v);
   endtask
   task automatic chk(input string name, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask
   task automatic drive(input logic r, f, input logic [1:0] p, c);
      @(negedge clk);
      rst = r;
      bus.flush = f;
      bus.rob_push_size = p;
      bus.rob_commit_size = c;
      @(posedge clk);
      #1;
   endtask
   task automatic check_all(input int idx, input int cnt, input logic rdy, err, emp, input int head, tail);
      chk("count", idx, int'(bus.rob_count), cnt);
      chk("ready", idx, int'(bus.rob_ready), int'(rdy));
      chk("err", idx, int'(bus.rob_err), int'(err));
      chk("empty", idx, int'(bus.rob_empty), int'(emp));
      chk("head_slot", idx, int'({bus.rob_head_id, bus.rob_head_bank}), head);
      chk("lane0_slot", idx, int'({bus.rob_free_id[1:0], bus.rob_free_bank[0]}), tail);
      chk("lane1_slot", idx, int'({bus.rob_free_id[3:2], bus.rob_free_bank[1]}), (tail + 1) % 8);
   endtask
   initial begin
      bus.flush = 1'b0;
      bus.rob_push_size = '0;
      bus.rob_commit_size = '0;
      //  r  f  p  c   cnt rdy err emp head tail
      add(1, 0, 0, 0,  0,  1,  0,  1,  0,   0);
      add(0, 0, 2, 0,  2,  1,  0,  0,  0,   2);
      add(0, 0, 2, 0,  4,  1,  0,  0,  0,   4);
      add(0, 0, 2, 0,  6,  1,  0,  0,  0,   6);
      add(0, 0, 2, 0,  8,  0,  0,  0,  0,   0);
      add(0, 0, 2, 2,  6,  1,  1,  0,  2,   0);
      add(1, 0, 0, 0,  0,  1,  0,  1,  0,   0);
      add(0, 0, 2, 0,  2,  1,  0,  0,  0,   2);
      add(0, 0, 2, 0,  4,  1,  0,  0,  0,   4);
      add(0, 0, 2, 0,  6,  1,  0,  0,  0,   6);
      add(0, 0, 1, 0,  7,  0,  0,  0,  0,   7);
      add(0, 0, 0, 1,  6,  1,  0,  0,  1,   7);
      add(0, 0, 0, 1,  5,  1,  0,  0,  2,   7);
      add(0, 1, 2, 0,  0,  0,  0,  1,  0,   0);
      add(0, 0, 2, 0,  0,  1,  0,  1,  0,   0);
      add(0, 0, 2, 0,  2,  1,  0,  0,  0,   2);
      add(0, 0, 0, 2,  0,  1,  0,  1,  2,   2);
      add(0, 0, 0, 1,  0,  1,  1,  1,  2,   2);
      add(0, 0, 2, 0,  2,  1,  1,  0,  2,   4);
      add(0, 1, 0, 0,  0,  0,  1,  1,  0,   0);
      add(0, 0, 0, 0,  0,  1,  1,  1,  0,   0);
      add(0, 0, 2, 0,  2,  1,  1,  0,  0,   2);
      add(0, 0, 2, 0,  4,  1,  1,  0,  0,   4);
      add(1, 1, 2, 0,  0,  1,  0,  1,  0,   0);
      add(0, 0, 3, 0,  0,  1,  1,  1,  0,   0);
      add(0, 0, 2, 1,  2,  1,  1,  0,  0,   2);
      foreach (vq[i]) begin
         drive(vq[i].r, vq[i].f, vq[i].p, vq[i].c);
         check_all(i, vq[i].cnt, vq[i].rdy, vq[i].err, vq[i].emp, vq[i].head, vq[i].tail);
      end
      // flush held two cycles keeps the allocator in recovery; push right after is still ignored
      drive(0, 1, 2, 0);
      check_all(100, 0, 0, 1, 1, 0, 0);
      drive(0, 1, 2, 1);
      check_all(101, 0, 0, 1, 1, 0, 0);
      drive(0, 0, 2, 0);
      check_all(102, 0, 1, 1, 1, 0, 0);
      drive(0, 0, 2, 0);
      check_all(103, 2, 1, 1, 0, 0, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
